// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests a byte at pc, holds it until decode
// accepts, then advances to next_pc or parks in HALTED on a halt indication.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] next_pc,
  input  logic       halt,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic       instr_ready,
  output logic [7:0] pc,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic       halted,
  output logic [7:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic       valid_q, valid_d;
  logic [7:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Inputs not relevant to the current state are never consulted, so stray
  // acks or accepts outside FETCH/HOLD have no effect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          valid_d = 1'b1;
          count_d = count_q + 8'd1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALTED);
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port next_pc  input  8  next PC from the next-PC logic, sampled only at instruction accept.
REQ-005 SHALL have port halt  input  1  decode's halt indication, sampled only at instruction accept.
REQ-006 SHALL have port imem_ack  input  1  memory read completes this cycle; imem_data valid.
REQ-007 SHALL have port imem_data  input  8  instruction byte from instruction memory.
REQ-008 SHALL have port instr_ready  input  1  decode accepts the held instruction.
REQ-009 SHALL have port pc  output  8  current PC register, fed to next_pc logic as curPC.
REQ-010 SHALL have port imem_req  output  1  read request to instruction memory.
REQ-011 SHALL have port imem_addr  output  8  read address; always equal to pc.
REQ-012 SHALL have port instr  output  8  fetched instruction register.
REQ-013 SHALL have port instr_valid  output  1  instr holds an unaccepted instruction.
REQ-014 SHALL have port halted  output  1  unit is in HALTED state.
REQ-015 SHALL have port fetch_count  output  8  number of completed fetches, modulo 256.

Function
REQ-016 SHALL implement four states: IDLE, FETCH, HOLD, HALTED; state held in a register.
REQ-017 SHALL drive imem_req = 1 only in FETCH; halted = 1 only in HALTED; both decoded from registered state.
REQ-018 SHALL transition IDLE -> FETCH unconditionally on the first edge with rst low.
REQ-019 SHALL, in FETCH with imem_ack = 1: load instr <= imem_data, set instr_valid <= 1, increment fetch_count, enter HOLD.
REQ-020 SHALL, in FETCH with imem_ack = 0: hold all registers, keep imem_req high with imem_addr stable (any number of wait cycles).
REQ-021 SHALL, in HOLD with instr_ready = 0: hold instr, instr_valid, pc unchanged; imem_req low.
REQ-022 SHALL, in HOLD with instr_ready = 1 and halt = 0: load pc <= next_pc, clear instr_valid, enter FETCH; new request visible the following cycle (accept-to-request latency 1 cycle).
REQ-023 SHALL, in HOLD with instr_ready = 1 and halt = 1: clear instr_valid, leave pc unchanged, enter HALTED.
REQ-024 SHALL remain in HALTED until rst; imem_ack, instr_ready, halt, next_pc ignored there.
REQ-025 SHALL ignore imem_ack and imem_data in IDLE, HOLD, HALTED.
REQ-026 SHALL ignore instr_ready and halt outside HOLD.
REQ-027 SHALL treat pc as unsigned 8-bit; wrap-around of next_pc (e.g. 0x00 with imm = -4 -> 0xFC) accepted unchanged, no flags.
REQ-028 SHALL wrap fetch_count from 255 to 0 without saturation.
REQ-029 SHALL permit minimum fetch cadence of one instruction per 2 cycles (ack in first FETCH cycle, ready in first HOLD cycle).

Reset
REQ-030 SHALL, on any edge with rst high regardless of state: pc <= RESET_PC, state <= IDLE, instr <= 0, instr_valid <= 0, fetch_count <= 0; rst has priority over all other inputs.
REQ-031 SHALL produce imem_req = 0, halted = 0, imem_addr = RESET_PC during and in the first cycle after reset.
REQ-032 SHALL discard an in-flight request or held instruction when rst asserts mid-operation; a late imem_ack after reset is ignored.

Verification
REQ-033 SHALL verify: rst 2 cycles, imem_ack after 2 wait cycles with imem_data = 0xA5 -> imem_addr = 0x00 throughout, instr = 0xA5, instr_valid = 1, fetch_count = 1.
REQ-034 SHALL verify: accept with next_pc = 0x79 -> pc = 0x79, imem_req = 1, imem_addr = 0x79 on the next cycle.
REQ-035 SHALL verify: instr_ready low 3 cycles in HOLD -> instr, pc stable, imem_req = 0; accepted on 4th.
REQ-036 SHALL verify: accept with halt = 1 -> halted = 1, imem_req = 0 permanently, pc unchanged, stray imem_ack ignored until rst.
REQ-037 SHALL verify: rst asserted in HOLD with instr = 0x3C -> next cycle instr_valid = 0, instr = 0, pc = 0x00, fetch_count = 0.
REQ-038 SHALL verify: 256 back-to-back fetches at minimum cadence -> fetch_count returns to 0; next_pc = 0xFC after pc = 0x00 fetched correctly.
